// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave exposing a bank of software-visible registers with byte-lane writes,
// SLVERR on out-of-range indices, parallel register export and a per-register write pulse.
module axi4_lite_slave_regfile #(
    parameter int C_DATA_WIDTH = 32,
    parameter int C_ADDR_BITS  = 10,
    parameter int C_REG_COUNT  = 16
) (
    input  logic                                CLK,
    input  logic                                nRST,
    input  logic [C_ADDR_BITS-1:0]              AWADDR,
    input  logic                                AWVALID,
    output logic                                AWREADY,
    input  logic [C_DATA_WIDTH-1:0]             WDATA,
    input  logic [C_DATA_WIDTH/8-1:0]           WSTRB,
    input  logic                                WVALID,
    output logic                                WREADY,
    output logic [1:0]                          BRESP,
    output logic                                BVALID,
    input  logic                                BREADY,
    input  logic [C_ADDR_BITS-1:0]              ARADDR,
    input  logic                                ARVALID,
    output logic                                ARREADY,
    output logic [C_DATA_WIDTH-1:0]             RDATA,
    output logic [1:0]                          RRESP,
    output logic                                RVALID,
    input  logic                                RREADY,
    output logic [C_REG_COUNT*C_DATA_WIDTH-1:0] REGS,
    output logic [C_REG_COUNT-1:0]              REG_WRITTEN
);
    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(STRB_W);
    localparam int IDX_W  = C_ADDR_BITS - OFFS;
    localparam logic [IDX_W:0] REG_LIMIT = (IDX_W + 1)'(C_REG_COUNT);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;

    logic                    aw_have_q, aw_have_d;
    logic [IDX_W-1:0]        aw_idx_q, aw_idx_d;
    logic                    w_have_q, w_have_d;
    logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic [1:0]              bresp_q, bresp_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [C_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;
    logic [C_DATA_WIDTH-1:0] regs_q [C_REG_COUNT];
    logic [C_DATA_WIDTH-1:0] regs_d [C_REG_COUNT];
    logic [C_REG_COUNT-1:0]  reg_written_q, reg_written_d;

    logic                    aw_fire, w_fire, ar_fire, aw_got, w_got, do_write;
    logic [IDX_W-1:0]        wr_idx, ar_idx;
    logic [C_DATA_WIDTH-1:0] wr_data, rd_val;
    logic [STRB_W-1:0]       wr_strb;
    logic                    addr_lsb_unused;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return {1'b0, idx} < REG_LIMIT;
    endfunction

    assign aw_fire  = AWVALID & awready_q;
    assign w_fire   = WVALID & wready_q;
    assign ar_fire  = ARVALID & arready_q;
    assign aw_got   = aw_have_q | aw_fire;
    assign w_got    = w_have_q | w_fire;
    assign do_write = (wr_state_q == WR_IDLE) & aw_got & w_got;
    // A beat arriving this edge takes precedence over the (empty) holding register.
    assign wr_idx   = aw_fire ? AWADDR[C_ADDR_BITS-1:OFFS] : aw_idx_q;
    assign wr_data  = w_fire ? WDATA : wdata_q;
    assign wr_strb  = w_fire ? WSTRB : wstrb_q;
    assign ar_idx   = ARADDR[C_ADDR_BITS-1:OFFS];
    assign addr_lsb_unused = ^{AWADDR[OFFS-1:0], ARADDR[OFFS-1:0]};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_state_q    <= WR_IDLE;
            rd_state_q    <= RD_IDLE;
            aw_have_q     <= 1'b0;
            aw_idx_q      <= '0;
            w_have_q      <= 1'b0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            awready_q     <= 1'b0;
            wready_q      <= 1'b0;
            bvalid_q      <= 1'b0;
            bresp_q       <= '0;
            arready_q     <= 1'b0;
            rvalid_q      <= 1'b0;
            rdata_q       <= '0;
            rresp_q       <= '0;
            reg_written_q <= '0;
            for (int i = 0; i < C_REG_COUNT; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_state_q    <= wr_state_d;
            rd_state_q    <= rd_state_d;
            aw_have_q     <= aw_have_d;
            aw_idx_q      <= aw_idx_d;
            w_have_q      <= w_have_d;
            wdata_q       <= wdata_d;
            wstrb_q       <= wstrb_d;
            awready_q     <= awready_d;
            wready_q      <= wready_d;
            bvalid_q      <= bvalid_d;
            bresp_q       <= bresp_d;
            arready_q     <= arready_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            rresp_q       <= rresp_d;
            reg_written_q <= reg_written_d;
            regs_q        <= regs_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        case (wr_state_q)
            WR_IDLE: if (do_write) wr_state_d = WR_RESP;
            WR_RESP: if (BREADY)   wr_state_d = WR_IDLE;
        endcase
        case (rd_state_q)
            RD_IDLE: if (ar_fire) rd_state_d = RD_DATA;
            RD_DATA: if (RREADY)  rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < C_REG_COUNT; i++) begin
            if (ar_idx == IDX_W'(i)) rd_val = regs_q[i];
        end
    end

    always_comb begin
        aw_have_d = aw_got & ~do_write;
        aw_idx_d  = wr_idx;
        w_have_d  = w_got & ~do_write;
        wdata_d   = wr_data;
        wstrb_d   = wr_strb;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        // Out-of-reset READYs come up on the first edge because ~aw_got etc. is 1 when idle.
        case (wr_state_q)
            WR_IDLE: begin
                awready_d = ~aw_got;
                wready_d  = ~w_got;
                bvalid_d  = do_write;
                if (do_write) bresp_d = in_range(wr_idx) ? RESP_OKAY : RESP_SLVERR;
            end
            WR_RESP: begin
                awready_d = BREADY;
                wready_d  = BREADY;
                bvalid_d  = ~BREADY;
            end
        endcase
        case (rd_state_q)
            RD_IDLE: begin
                arready_d = ~ar_fire;
                rvalid_d  = ar_fire;
                if (ar_fire) begin
                    rdata_d = rd_val;
                    rresp_d = in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
                end
            end
            RD_DATA: begin
                arready_d = RREADY;
                rvalid_d  = ~RREADY;
            end
        endcase
        reg_written_d = '0;
        for (int i = 0; i < C_REG_COUNT; i++) begin
            regs_d[i] = regs_q[i];
            if (do_write && wr_idx == IDX_W'(i)) begin
                reg_written_d[i] = 1'b1;
                for (int b = 0; b < STRB_W; b++) begin
                    if (wr_strb[b]) regs_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign AWREADY     = awready_q;
    assign WREADY      = wready_q;
    assign BVALID      = bvalid_q;
    assign BRESP       = bresp_q;
    assign ARREADY     = arready_q;
    assign RVALID      = rvalid_q;
    assign RDATA       = rdata_q;
    assign RRESP       = rresp_q;
    assign REG_WRITTEN = reg_written_q;

    for (genvar gi = 0; gi < C_REG_COUNT; gi++) begin : g_regs_out
        assign REGS[gi*C_DATA_WIDTH +: C_DATA_WIDTH] = regs_q[gi];
    end
endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Bench for axi4_lite_slave_regfile: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model of the register bank and channel handshakes.
module tb_axi4_lite_slave_regfile;
    logic         CLK = 1'b0;
    logic         nRST = 1'b0;
    logic [9:0]   AWADDR = '0;
    logic         AWVALID = 1'b0;
    logic         AWREADY;
    logic [31:0]  WDATA = '0;
    logic [3:0]   WSTRB = '0;
    logic         WVALID = 1'b0;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY = 1'b0;
    logic [9:0]   ARADDR = '0;
    logic         ARVALID = 1'b0;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY = 1'b0;
    logic [511:0] REGS;
    logic [15:0]  REG_WRITTEN;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    axi4_lite_slave_regfile #(.C_DATA_WIDTH(32), .C_ADDR_BITS(10), .C_REG_COUNT(16)) dut (
        .CLK(CLK), .nRST(nRST),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .REGS(REGS), .REG_WRITTEN(REG_WRITTEN)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got timeout, expected handshake at %0t", name, $time);
    endtask

    // Transaction-level model: pending flags per channel and an array of register values.
    logic        m_live, m_aw, m_w, m_b, m_r;
    logic [9:0]  m_awaddr;
    logic [31:0] m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp, m_rresp;
    logic [15:0] m_pulse;
    logic [31:0] mregs [16];

    wire exp_awready = m_live && !m_aw && !m_b;
    wire exp_wready  = m_live && !m_w && !m_b;
    wire exp_arready = m_live && !m_r;

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            m_live = 0; m_aw = 0; m_w = 0; m_b = 0; m_r = 0;
            m_awaddr = 0; m_wdata = 0; m_wstrb = 0; m_rdata = 0;
            m_bresp = 0; m_rresp = 0; m_pulse = 0;
            for (int i = 0; i < 16; i++) mregs[i] = 0;
        end else begin
            automatic logic awr = m_live && !m_aw && !m_b;
            automatic logic wrr = m_live && !m_w && !m_b;
            automatic logic arr = m_live && !m_r;
            automatic int idx;
            m_pulse = 0;
            if (m_r) begin
                if (RREADY) m_r = 0;
            end else if (arr && ARVALID) begin
                idx = int'(ARADDR[9:2]);
                m_r = 1;
                m_rdata = (idx < 16) ? mregs[idx] : 32'h0;
                m_rresp = (idx < 16) ? 2'b00 : 2'b10;
                $display("rd idx %0d data %h resp %0d", idx, m_rdata, m_rresp);
            end
            if (m_b) begin
                if (BREADY) m_b = 0;
            end else begin
                if (awr && AWVALID) begin m_aw = 1; m_awaddr = AWADDR; end
                if (wrr && WVALID) begin m_w = 1; m_wdata = WDATA; m_wstrb = WSTRB; end
                if (m_aw && m_w) begin
                    idx = int'(m_awaddr[9:2]);
                    m_aw = 0; m_w = 0; m_b = 1;
                    if (idx < 16) begin
                        for (int b = 0; b < 4; b++)
                            if (m_wstrb[b]) mregs[idx][b*8 +: 8] = m_wdata[b*8 +: 8];
                        m_pulse = 16'(1) << idx;
                        m_bresp = 2'b00;
                    end else begin
                        m_bresp = 2'b10;
                    end
                    $display("wr idx %0d data %h strb %h resp %0d", idx, m_wdata, m_wstrb, m_bresp);
                end
            end
            m_live = 1;
        end
    end

    always @(posedge CLK) begin
        #1;
        chk("awready", AWREADY, exp_awready);
        chk("wready", WREADY, exp_wready);
        chk("arready", ARREADY, exp_arready);
        chk("bvalid", BVALID, m_b);
        chk("bresp", BRESP, m_bresp);
        chk("rvalid", RVALID, m_r);
        chk("rdata", RDATA, m_rdata);
        chk("rresp", RRESP, m_rresp);
        chk("reg_written", REG_WRITTEN, m_pulse);
        for (int i = 0; i < 16; i++) chk($sformatf("regs[%0d]", i), REGS[i*32 +: 32], mregs[i]);
    end

    task automatic write_req(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly);
        automatic bit aw_done = 0, w_done = 0, awa, wa;
        automatic int cyc = 0;
        while (!(aw_done && w_done)) begin
            @(negedge CLK);
            AWADDR = a; WDATA = d; WSTRB = s;
            AWVALID = !aw_done && cyc >= aw_dly;
            WVALID  = !w_done && cyc >= w_dly;
            awa = AWVALID && exp_awready;
            wa  = WVALID && exp_wready;
            @(posedge CLK);
            if (awa) aw_done = 1;
            if (wa) w_done = 1;
            if (++cyc > 60) begin timeout_fail("write_accept"); break; end
        end
    endtask

    task automatic finish_b(input int dly, input bit poke_aw);
        automatic int cnt = 0;
        @(negedge CLK);
        AWVALID = 0; WVALID = 0;
        if (poke_aw) begin AWVALID = 1; AWADDR = 10'h00C; WDATA = 32'h5A5A5A5A; end
        repeat (dly) @(negedge CLK);
        BREADY = 1; AWVALID = 0;
        while (m_b) begin
            @(negedge CLK);
            if (++cnt > 20) begin timeout_fail("b_handshake"); break; end
        end
        BREADY = 0;
    endtask

    task automatic read_req(input logic [9:0] a, input int ar_dly);
        automatic bit done = 0, ara;
        automatic int cyc = 0;
        while (!done) begin
            @(negedge CLK);
            ARADDR = a;
            ARVALID = cyc >= ar_dly;
            ara = ARVALID && exp_arready;
            @(posedge CLK);
            if (ara) done = 1;
            if (++cyc > 60) begin timeout_fail("read_accept"); break; end
        end
    endtask

    task automatic finish_r(input int dly);
        automatic int cnt = 0;
        @(negedge CLK);
        ARVALID = 0;
        repeat (dly) @(negedge CLK);
        RREADY = 1;
        while (m_r) begin
            @(negedge CLK);
            if (++cnt > 20) begin timeout_fail("r_handshake"); break; end
        end
        RREADY = 0;
    endtask

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_awready", AWREADY, 0);
        chk("reset_bvalid", BVALID, 0);
        chk("reset_regs_nonzero", (REGS == '0) ? 0 : 1, 0);
        @(negedge CLK); nRST = 1;
        @(posedge CLK); #1;
        chk("first_edge_awready", AWREADY, 1);
        chk("first_edge_wready", WREADY, 1);
        chk("first_edge_arready", ARREADY, 1);

        write_req(10'h004, 32'hDEADBEEF, 4'hF, 0, 0);
        #1;
        chk("same_cycle_reg1", REGS[63:32], 32'hDEADBEEF);
        chk("same_cycle_bvalid", BVALID, 1);
        chk("same_cycle_bresp", BRESP, 2'b00);
        chk("same_cycle_pulse", REG_WRITTEN, 16'h0002);
        @(posedge CLK); #1;
        chk("pulse_one_cycle", REG_WRITTEN, 16'h0000);
        finish_b(0, 0);
        read_req(10'h004, 0);
        #1;
        chk("read_back_rdata", RDATA, 32'hDEADBEEF);
        chk("read_back_rresp", RRESP, 2'b00);
        finish_r(0);

        write_req(10'h004, 32'h0000AA00, 4'b0010, 3, 0);
        #1;
        chk("data_first_reg1", REGS[63:32], 32'hDEADAAEF);
        finish_b(0, 0);

        write_req(10'h040, 32'h12345678, 4'hF, 0, 0);
        #1;
        chk("oor_bresp", BRESP, 2'b10);
        chk("oor_pulse", REG_WRITTEN, 16'h0000);
        finish_b(0, 0);
        read_req(10'h040, 0);
        #1;
        chk("oor_rdata", RDATA, 32'h0);
        chk("oor_rresp", RRESP, 2'b10);
        finish_r(0);

        write_req(10'h014, 32'h0BADF00D, 4'hF, 0, 0);
        finish_b(5, 1);
        #1;
        chk("bp_no_aw_accept_reg3", REGS[127:96], 32'h0);
        read_req(10'h014, 1);
        finish_r(5);

        write_req(10'h008, 32'h11111111, 4'hF, 0, 0);
        finish_b(0, 0);
        @(negedge CLK);
        ARADDR = 10'h008; ARVALID = 1;
        AWADDR = 10'h008; AWVALID = 1; WDATA = 32'h22222222; WSTRB = 4'hF; WVALID = 1;
        @(posedge CLK); #1;
        chk("collision_rdata", RDATA, 32'h11111111);
        chk("collision_reg2", REGS[95:64], 32'h22222222);
        fork
            finish_b(0, 0);
            finish_r(0);
        join

        for (int it = 0; it < 120; it++) begin
            automatic int op = $urandom_range(0, 2);
            automatic int wi = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
            automatic int ri = ($urandom_range(0, 7) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15);
            automatic logic [9:0] wa = 10'(wi * 4 + $urandom_range(0, 3));
            automatic logic [9:0] ra = 10'(ri * 4 + $urandom_range(0, 3));
            automatic logic [31:0] wd = $urandom;
            automatic logic [3:0] ws = 4'($urandom_range(0, 15));
            automatic int ad = $urandom_range(0, 3), wdl = $urandom_range(0, 3);
            automatic int bd = $urandom_range(0, 3), rdl = $urandom_range(0, 3);
            fork
                if (op != 1) begin write_req(wa, wd, ws, ad, wdl); finish_b(bd, bd[0]); end
                if (op != 0) begin read_req(ra, ad); finish_r(rdl); end
            join
        end

        write_req(10'h010, 32'hCAFEF00D, 4'hF, 0, 0);
        #1;
        chk("pre_async_bvalid", BVALID, 1);
        #2;
        nRST = 0; AWVALID = 0; WVALID = 0;
        #1;
        chk("async_bvalid", BVALID, 0);
        chk("async_regs_nonzero", (REGS == '0) ? 0 : 1, 0);
        repeat (3) @(posedge CLK);
        @(negedge CLK); nRST = 1;
        repeat (2) @(posedge CLK);
        #1;
        chk("post_async_awready", AWREADY, 1);
        chk("post_async_bvalid", BVALID, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/axi4_lite_slave_regfile.md
# axi4_lite_slave_regfile

AXI4-Lite slave register file: the RTL responder that answers the AXI4-Lite master BFM in SystemSim and gives DUT-side logic a bank of software-visible control registers. It accepts single-beat writes (AW/W/B) and reads (AR/R), and applies WSTRB byte enables. Addresses outside the bank get a SLVERR response. Every register value is exported in parallel, together with a per-register write pulse.

## Interface
Parameters:
- C_DATA_WIDTH, 32, data bus width; 32 or 64.
- C_ADDR_BITS, 10, AXI address width.
- C_REG_COUNT, 16, number of registers; must satisfy C_REG_COUNT <= 2^(C_ADDR_BITS-log2(C_DATA_WIDTH/8)).

Ports:
- CLK  in  1  single clock; all logic is on the rising edge.
- nRST  in  1  reset; one clock; reset is asynchronous and active-low.
- AWADDR  in  C_ADDR_BITS  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready (registered).
- WDATA  in  C_DATA_WIDTH  write data.
- WSTRB  in  C_DATA_WIDTH/8  byte enables.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready (registered).
- BRESP  out  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  C_ADDR_BITS  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready (registered).
- RDATA  out  C_DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- REGS  out  C_REG_COUNT*C_DATA_WIDTH  register contents; register i is at bits [i*C_DATA_WIDTH +: C_DATA_WIDTH].
- REG_WRITTEN  out  C_REG_COUNT  one-hot, one-cycle pulse for the register updated on the previous edge.

## Operation
- Index = ADDR[C_ADDR_BITS-1 : log2(C_DATA_WIDTH/8)]. The low byte-offset bits are ignored.
- An index >= C_REG_COUNT is out of range.
- Reset (nRST low, asynchronous):
  - All outputs are 0, including the READYs, RDATA, the RESPs and REGS.
  - Any pending capture is discarded; this applies equally to a transaction in flight when reset is asserted.
- On the first CLK edge with nRST high, AWREADY, WREADY and ARREADY become 1.
- Write channel: one outstanding transaction. States are IDLE and RESP.
  - IDLE, address capture: AW is captured on AWVALID&AWREADY; AWREADY then drops to 0 and stays 0 until the B handshake.
  - IDLE, data capture: W is captured on WVALID&WREADY and is handled the same way. AW and W may arrive in either order or on the same edge.
  - IDLE -> RESP: on the edge where the second of AW/W is accepted (or both together), the write is applied on that same edge.
    - In range: byte lane k of the register is updated only where WSTRB[k]=1.
    - In range: BRESP=00, and REG_WRITTEN[index]=1 for one cycle. The pulse occurs even if WSTRB=0.
    - Out of range: no register changes, no pulse, BRESP=10.
    - BVALID=1 on the same edge.
  - RESP: BVALID, BRESP, AWREADY=0 and WREADY=0 are all held until BVALID&BREADY.
  - RESP -> IDLE: on that handshake edge BVALID=0 and AWREADY=WREADY=1.
- Read channel: independent of the write channel. States are IDLE and DATA.
  - IDLE (ARREADY=1): on ARVALID&ARREADY, RDATA and RRESP are loaded and RVALID=1, ARREADY=0.
    - In range: RDATA = the register's value before this edge, RRESP=00.
    - Out of range: RDATA=0, RRESP=10.
  - DATA: RDATA, RRESP and RVALID are held stable until RVALID&RREADY. On that edge RVALID=0 and ARREADY=1.
- Same-edge read and write to the same register: the read returns the old value and the write takes effect.
- REGS updates on the write edge; it is a direct register output with no extra delay.

## Timing
- Write latency: AW/W accept at edge N, then the register update, BVALID and REG_WRITTEN all appear after edge N.
- Earliest next write: BREADY=1 completes the handshake at edge N+1, and the next AW/W is accepted at edge N+2. Peak rate is one write per 2 cycles.
- Read latency: AR accept at edge N gives RVALID after edge N. With RREADY=1 the handshake is at N+1 and the next AR is accepted at N+2.
- The BVALID/RVALID-to-READY path is registered: no combinational path from any input to any output.
- REG_WRITTEN is low in every cycle that does not follow an in-range write.

## Test plan
- Reset: hold nRST low for 3 cycles.
  - Required: all outputs 0.
  - Required: after the first edge with nRST high, AWREADY=WREADY=ARREADY=1.
  - Then assert nRST low asynchronously, between edges, while BVALID=1. Required: BVALID drops immediately and REGS returns to 0.
- Same-cycle write: AW=0x004 and W=0xDEADBEEF with WSTRB=4'hF together.
  - Required: REGS[1]=0xDEADBEEF, BVALID=1 with BRESP=00, and REG_WRITTEN=16'h0002 for exactly one cycle.
  - Then read 0x004. Required: RDATA=0xDEADBEEF, RRESP=00.
- Data-first partial write: W=0x0000AA00 with WSTRB=4'b0010 arrives 3 cycles before AW=0x004.
  - Required: WREADY=0 while waiting, then REGS[1]=0xDEADAAEF.
- Out-of-range access (C_REG_COUNT=16): write to 0x040.
  - Required: BRESP=10, no REGS change, no REG_WRITTEN pulse.
  - Then read 0x040. Required: RDATA=0, RRESP=10.
- Backpressure: hold BREADY=0 for 5 cycles.
  - Required: BVALID and BRESP stay stable, AWREADY=WREADY=0, and a new AWVALID is not accepted.
  - Repeat with RREADY=0. Required: RDATA stays stable.
- Collision: REGS[2]=0x11111111, then a read of 0x008 and a write of 0x22222222 to 0x008 are accepted on the same edge.
  - Required: RDATA=0x11111111 and REGS[2]=0x22222222.
